ascon_ctrl_fsm: RTL and testbench

// - Sequencing controller for the Ascon-128 round datapath. Drives the datapath's control inputs
//   (en_state, sel_*, ct_valid, tag_valid) and its round counter rnd.
// - Moves one job through INIT -> AD blocks -> PT blocks -> FINAL -> tag, one round per cycle.
// - Upstream (padder/bus side) exchanges pre-padded 64-bit blocks via valid/ready. Block data

---
 rtl/ascon_ctrl_fsm.sv | 222 ++++++++++++++++++++++
 tb/tb_ascon_ctrl_fsm.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/ascon_ctrl_fsm.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ascon_ctrl_fsm: Ascon-128 round-datapath sequencer (INIT/AD/PT/FINAL/tag). |
// | Optional macro ASCON_CTRL_ABORT_EN adds a synchronous abort_i input.       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module ascon_ctrl_fsm #(
  parameter int ROUND_WIDTH = 4,
  parameter int ROUND_NO    = 12,
  parameter int PB_ROUNDS   = 6
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start_i,
  input  logic                   has_ad_i,
  input  logic                   ad_valid_i,
  input  logic                   ad_last_i,
  output logic                   ad_ready_o,
  input  logic                   pt_valid_i,
  input  logic                   pt_last_i,
  output logic                   pt_ready_o,
  input  logic                   tag_ready_i,
`ifdef ASCON_CTRL_ABORT_EN
  input  logic                   abort_i,
`endif
  output logic                   busy_o,
  output logic                   en_state_o,
  output logic                   sel_ad_o,
  output logic                   sel_state_init_o,
  output logic                   sel_xor_init_o,
  output logic                   sel_xor_ext_o,
  output logic                   sel_xor_dom_sep_o,
  output logic                   sel_xor_fin_o,
  output logic                   sel_xor_tag_o,
  output logic                   ct_valid_o,
  output logic                   tag_valid_o,
  output logic [ROUND_WIDTH-1:0] rnd_o
);

  localparam logic [ROUND_WIDTH-1:0] c_rnd_zero     = '0;
  localparam logic [ROUND_WIDTH-1:0] c_rnd_one      = ROUND_WIDTH'(1);
  localparam logic [ROUND_WIDTH-1:0] c_rnd_last     = ROUND_WIDTH'(ROUND_NO - 1);
  localparam logic [ROUND_WIDTH-1:0] c_rnd_pb_first = ROUND_WIDTH'(ROUND_NO - PB_ROUNDS);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_INIT    = 3'd1,
    S_AD_WAIT = 3'd2,
    S_AD      = 3'd3,
    S_PT_WAIT = 3'd4,
    S_PT      = 3'd5,
    S_FINAL   = 3'd6,
    S_DONE    = 3'd7
  } state_t;

  state_t                 r_state, w_state_nxt;
  logic [ROUND_WIDTH-1:0] r_rnd, w_rnd_nxt;
  logic                   r_has_ad, w_has_ad_nxt;
  logic                   r_ad_last, w_ad_last_nxt;
  logic                   w_rnd_last;
  logic                   w_abort;

`ifdef ASCON_CTRL_ABORT_EN
  assign w_abort = abort_i;
`else
  assign w_abort = 1'b0;
`endif

  assign w_rnd_last = (r_rnd == c_rnd_last);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_rnd     <= c_rnd_zero;
      r_has_ad  <= 1'b0;
      r_ad_last <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_rnd     <= w_rnd_nxt;
      r_has_ad  <= w_has_ad_nxt;
      r_ad_last <= w_ad_last_nxt;
    end
  end

  always_comb begin
    w_state_nxt       = r_state;
    w_rnd_nxt         = r_rnd;
    w_has_ad_nxt      = r_has_ad;
    w_ad_last_nxt     = r_ad_last;
    ad_ready_o        = 1'b0;
    pt_ready_o        = 1'b0;
    en_state_o        = 1'b0;
    sel_ad_o          = 1'b0;
    sel_state_init_o  = 1'b0;
    sel_xor_init_o    = 1'b0;
    sel_xor_ext_o     = 1'b0;
    sel_xor_dom_sep_o = 1'b0;
    sel_xor_fin_o     = 1'b0;
    sel_xor_tag_o     = 1'b0;
    ct_valid_o        = 1'b0;
    tag_valid_o       = 1'b0;
    rnd_o             = c_rnd_zero;
    busy_o            = (r_state != S_IDLE);

    case (r_state)
      S_IDLE: begin
        if (start_i) begin
          w_state_nxt  = S_INIT;
          w_rnd_nxt    = c_rnd_zero;
          w_has_ad_nxt = has_ad_i;
        end
      end
      S_INIT: begin
        en_state_o       = 1'b1;
        rnd_o            = r_rnd;
        sel_state_init_o = (r_rnd == c_rnd_zero);
        if (w_rnd_last) begin
          sel_xor_init_o    = 1'b1;
          sel_xor_dom_sep_o = !r_has_ad;
          w_state_nxt       = r_has_ad ? S_AD_WAIT : S_PT_WAIT;
        end else begin
          w_rnd_nxt = r_rnd + c_rnd_one;
        end
      end
      // The handshake cycle itself is the first p^b round of the block.
      S_AD_WAIT: begin
        ad_ready_o = 1'b1;
        if (ad_valid_i) begin
          en_state_o    = 1'b1;
          sel_xor_ext_o = 1'b1;
          sel_ad_o      = 1'b1;
          rnd_o         = c_rnd_pb_first;
          w_ad_last_nxt = ad_last_i;
          w_rnd_nxt     = c_rnd_pb_first + c_rnd_one;
          w_state_nxt   = S_AD;
        end
      end
      S_AD: begin
        en_state_o = 1'b1;
        sel_ad_o   = 1'b1;
        rnd_o      = r_rnd;
        if (w_rnd_last) begin
          sel_xor_dom_sep_o = r_ad_last;
          w_state_nxt       = r_ad_last ? S_PT_WAIT : S_AD_WAIT;
        end else begin
          w_rnd_nxt = r_rnd + c_rnd_one;
        end
      end
      S_PT_WAIT: begin
        pt_ready_o = 1'b1;
        if (pt_valid_i) begin
          en_state_o    = 1'b1;
          sel_xor_ext_o = 1'b1;
          ct_valid_o    = 1'b1;
          if (pt_last_i) begin
            sel_xor_fin_o = 1'b1;
            rnd_o         = c_rnd_zero;
            w_rnd_nxt     = c_rnd_one;
            w_state_nxt   = S_FINAL;
          end else begin
            rnd_o       = c_rnd_pb_first;
            w_rnd_nxt   = c_rnd_pb_first + c_rnd_one;
            w_state_nxt = S_PT;
          end
        end
      end
      S_PT: begin
        en_state_o = 1'b1;
        rnd_o      = r_rnd;
        if (w_rnd_last) begin
          w_state_nxt = S_PT_WAIT;
        end else begin
          w_rnd_nxt = r_rnd + c_rnd_one;
        end
      end
      S_FINAL: begin
        en_state_o = 1'b1;
        rnd_o      = r_rnd;
        if (w_rnd_last) begin
          sel_xor_tag_o = 1'b1;
          w_state_nxt   = S_DONE;
        end else begin
          w_rnd_nxt = r_rnd + c_rnd_one;
        end
      end
      S_DONE: begin
        tag_valid_o = 1'b1;
        if (tag_ready_i) begin
          w_state_nxt = S_IDLE;
          w_rnd_nxt   = c_rnd_zero;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_rnd_nxt   = c_rnd_zero;
      end
    endcase

    // Abort silences the datapath this cycle and overrides every transition.
    if (w_abort) begin
      ad_ready_o        = 1'b0;
      pt_ready_o        = 1'b0;
      en_state_o        = 1'b0;
      sel_ad_o          = 1'b0;
      sel_state_init_o  = 1'b0;
      sel_xor_init_o    = 1'b0;
      sel_xor_ext_o     = 1'b0;
      sel_xor_dom_sep_o = 1'b0;
      sel_xor_fin_o     = 1'b0;
      sel_xor_tag_o     = 1'b0;
      ct_valid_o        = 1'b0;
      tag_valid_o       = 1'b0;
      rnd_o             = c_rnd_zero;
      w_state_nxt       = S_IDLE;
      w_rnd_nxt         = c_rnd_zero;
      w_has_ad_nxt      = 1'b0;
      w_ad_last_nxt     = 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ascon_ctrl_fsm.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_ascon_ctrl_fsm: directed cycle-by-cycle vectors for ascon_ctrl_fsm.     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_ascon_ctrl_fsm;

  // Output vector bit positions
  localparam logic [12:0] O_BUSY = 13'h1000;
  localparam logic [12:0] O_ADR  = 13'h0800;
  localparam logic [12:0] O_PTR  = 13'h0400;
  localparam logic [12:0] O_EN   = 13'h0200;
  localparam logic [12:0] O_SAD  = 13'h0100;
  localparam logic [12:0] O_SSI  = 13'h0080;
  localparam logic [12:0] O_SXI  = 13'h0040;
  localparam logic [12:0] O_SXE  = 13'h0020;
  localparam logic [12:0] O_DS   = 13'h0010;
  localparam logic [12:0] O_FIN  = 13'h0008;
  localparam logic [12:0] O_TAG  = 13'h0004;
  localparam logic [12:0] O_CT   = 13'h0002;
  localparam logic [12:0] O_TV   = 13'h0001;

  // Input vector bit positions
  localparam logic [6:0] I_NONE  = 7'h00;
  localparam logic [6:0] I_START = 7'h40;
  localparam logic [6:0] I_HASAD = 7'h20;
  localparam logic [6:0] I_ADV   = 7'h10;
  localparam logic [6:0] I_ADL   = 7'h08;
  localparam logic [6:0] I_PTV   = 7'h04;
  localparam logic [6:0] I_PTL   = 7'h02;
  localparam logic [6:0] I_TAGR  = 7'h01;

  typedef struct {
    logic [6:0]  in;
    int          n;
    logic [12:0] exp;
    logic [3:0]  rnd;
    bit          inc;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start_i = 1'b0, has_ad_i = 1'b0, ad_valid_i = 1'b0, ad_last_i = 1'b0;
  logic pt_valid_i = 1'b0, pt_last_i = 1'b0, tag_ready_i = 1'b0;
`ifdef ASCON_CTRL_ABORT_EN
  logic abort_i = 1'b0;
`endif
  logic ad_ready_o, pt_ready_o, busy_o, en_state_o, sel_ad_o, sel_state_init_o;
  logic sel_xor_init_o, sel_xor_ext_o, sel_xor_dom_sep_o, sel_xor_fin_o;
  logic sel_xor_tag_o, ct_valid_o, tag_valid_o;
  logic [3:0] rnd_o;
  logic [12:0] out_vec;

  int checks = 0;
  int errors = 0;
  vec_t tbl[$];

  always #5 clk = ~clk;

  ascon_ctrl_fsm #(.ROUND_WIDTH(4), .ROUND_NO(12), .PB_ROUNDS(6)) dut (
    .clk               (clk),
    .rst               (rst),
    .start_i           (start_i),
    .has_ad_i          (has_ad_i),
    .ad_valid_i        (ad_valid_i),
    .ad_last_i         (ad_last_i),
    .ad_ready_o        (ad_ready_o),
    .pt_valid_i        (pt_valid_i),
    .pt_last_i         (pt_last_i),
    .pt_ready_o        (pt_ready_o),
    .tag_ready_i       (tag_ready_i),
`ifdef ASCON_CTRL_ABORT_EN
    .abort_i           (abort_i),
`endif
    .busy_o            (busy_o),
    .en_state_o        (en_state_o),
    .sel_ad_o          (sel_ad_o),
    .sel_state_init_o  (sel_state_init_o),
    .sel_xor_init_o    (sel_xor_init_o),
    .sel_xor_ext_o     (sel_xor_ext_o),
    .sel_xor_dom_sep_o (sel_xor_dom_sep_o),
    .sel_xor_fin_o     (sel_xor_fin_o),
    .sel_xor_tag_o     (sel_xor_tag_o),
    .ct_valid_o        (ct_valid_o),
    .tag_valid_o       (tag_valid_o),
    .rnd_o             (rnd_o)
  );

  assign out_vec = {busy_o, ad_ready_o, pt_ready_o, en_state_o, sel_ad_o,
                    sel_state_init_o, sel_xor_init_o, sel_xor_ext_o,
                    sel_xor_dom_sep_o, sel_xor_fin_o, sel_xor_tag_o,
                    ct_valid_o, tag_valid_o};

  task automatic add(input logic [6:0] in, input int n, input logic [12:0] e,
                     input logic [3:0] r, input bit inc);
    vec_t v;
    v.in = in; v.n = n; v.exp = e; v.rnd = r; v.inc = inc;
    tbl.push_back(v);
  endtask

  task automatic chk(input string name, input logic [12:0] e, input logic [3:0] r);
    checks++;
    if (out_vec !== e || rnd_o !== r) begin
      errors++;
      $display("FAIL %s: got out=%b rnd=%0d, expected out=%b rnd=%0d",
               name, out_vec, rnd_o, e, r);
    end
  endtask

  task automatic drv(input logic [6:0] in);
    @(negedge clk);
    {start_i, has_ad_i, ad_valid_i, ad_last_i, pt_valid_i, pt_last_i, tag_ready_i} = in;
  endtask

  task automatic step(input string name, input logic [6:0] in,
                      input logic [12:0] e, input logic [3:0] r);
    drv(in);
    #1;
    chk(name, e, r);
  endtask

  initial begin
    // Job 1: no AD, single last PT block; DONE lands 25 cycles after start.
    add(I_NONE,  2, 13'h0, 4'd0, 0);
    add(I_START, 1, 13'h0, 4'd0, 0);
    add(I_NONE,  1, O_BUSY|O_EN|O_SSI, 4'd0, 0);
    add(I_NONE, 10, O_BUSY|O_EN, 4'd1, 1);
    add(I_NONE,  1, O_BUSY|O_EN|O_SXI|O_DS, 4'd11, 0);
    add(I_PTV|I_PTL, 1, O_BUSY|O_PTR|O_EN|O_SXE|O_CT|O_FIN, 4'd0, 0);
    add(I_NONE, 10, O_BUSY|O_EN, 4'd1, 1);
    add(I_NONE,  1, O_BUSY|O_EN|O_TAG, 4'd11, 0);
    add(I_TAGR,  1, O_BUSY|O_TV, 4'd0, 0);
    add(I_NONE,  1, 13'h0, 4'd0, 0);
    // Job 2: 2 AD blocks with a 3-cycle stall, 3 PT blocks, DONE held with start high.
    add(I_START|I_HASAD, 1, 13'h0, 4'd0, 0);
    add(I_NONE,  1, O_BUSY|O_EN|O_SSI, 4'd0, 0);
    add(I_START, 10, O_BUSY|O_EN, 4'd1, 1);
    add(I_NONE,  1, O_BUSY|O_EN|O_SXI, 4'd11, 0);
    add(I_ADV,   1, O_BUSY|O_ADR|O_EN|O_SXE|O_SAD, 4'd6, 0);
    add(I_NONE,  4, O_BUSY|O_EN|O_SAD, 4'd7, 1);
    add(I_NONE,  1, O_BUSY|O_EN|O_SAD, 4'd11, 0);
    add(I_NONE,  3, O_BUSY|O_ADR, 4'd0, 0);
    add(I_ADV|I_ADL, 1, O_BUSY|O_ADR|O_EN|O_SXE|O_SAD, 4'd6, 0);
    add(I_NONE,  4, O_BUSY|O_EN|O_SAD, 4'd7, 1);
    add(I_NONE,  1, O_BUSY|O_EN|O_SAD|O_DS, 4'd11, 0);
    add(I_NONE,  1, O_BUSY|O_PTR, 4'd0, 0);
    add(I_PTV,   1, O_BUSY|O_PTR|O_EN|O_SXE|O_CT, 4'd6, 0);
    add(I_NONE,  5, O_BUSY|O_EN, 4'd7, 1);
    add(I_PTV,   1, O_BUSY|O_PTR|O_EN|O_SXE|O_CT, 4'd6, 0);
    add(I_NONE,  5, O_BUSY|O_EN, 4'd7, 1);
    add(I_PTV|I_PTL, 1, O_BUSY|O_PTR|O_EN|O_SXE|O_CT|O_FIN, 4'd0, 0);
    add(I_NONE, 10, O_BUSY|O_EN, 4'd1, 1);
    add(I_NONE,  1, O_BUSY|O_EN|O_TAG, 4'd11, 0);
    add(I_START, 10, O_BUSY|O_TV, 4'd0, 0);
    add(I_TAGR,  1, O_BUSY|O_TV, 4'd0, 0);
    add(I_NONE,  1, 13'h0, 4'd0, 0);

    repeat (3) @(negedge clk);
    #1;
    chk("reset_state", 13'h0, 4'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int r = 0; r < tbl.size(); r++) begin
      for (int k = 0; k < tbl[r].n; k++) begin
        step($sformatf("row%0d.%0d", r, k), tbl[r].in, tbl[r].exp,
             tbl[r].inc ? tbl[r].rnd + 4'(k) : tbl[r].rnd);
      end
    end

    // Asynchronous reset in the middle of FINAL.
    drv(I_START);
    repeat (13) drv(I_PTV|I_PTL);
    repeat (3) drv(I_NONE);
    #1;
    chk("final_before_rst", O_BUSY|O_EN, 4'd3);
    #1;
    rst = 1'b1;
    #1;
    chk("async_rst", 13'h0, 4'd0);
    @(negedge clk);
    rst = 1'b0;
    step("idle_after_rst", I_NONE, 13'h0, 4'd0);

`ifdef ASCON_CTRL_ABORT_EN
    drv(I_START|I_HASAD);
    repeat (12) drv(I_NONE);
    drv(I_ADV);
    drv(I_NONE);
    #1;
    chk("ad_before_abort", O_BUSY|O_EN|O_SAD, 4'd7);
    @(negedge clk);
    abort_i = 1'b1;
    #1;
    chk("abort_cycle", O_BUSY, 4'd0);
    @(negedge clk);
    abort_i = 1'b0;
    #1;
    chk("idle_after_abort", 13'h0, 4'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
